trdb_packet_unpacker: RTL and testbench
=======================================

// Module: trdb_packet_unpacker
//
// PURPOSE
// - Receive end of the trace debugger packet stream.
// - Takes the 32-bit word stream emitted by the trace debugger packer.
// - Reassembles each variable-length trace packet from its header length field.
// - Presents each whole packet on a single valid/ready output for the host-side
//   decoder and for testbench scoreboards.
// - Sits between the trace debugger word output and the packet consumer.
//
// PARAMETERS
// - MAX_WORDS  default 4  maximum packet length in words, header included (2..15)
// - LEN_W      default 4  width of the header length field; header bits [LEN_W-1:0]
//
// PORTS
// - clk_i           in   1               clock; all logic on the rising edge
// - rst_i           in   1               synchronous reset, active-high
// - word_i          in   32              packed trace word
// - word_valid_i    in   1               word_i is valid
// - word_ready_o    out  1               unpacker accepts word_i this cycle
// - flush_i         in   1               drop any partially collected packet
// - packet_o        out  MAX_WORDS*32    packet; word k is at bits [32k+31:32k]
// - packet_len_o    out  LEN_W           packet length in words, header included
// - packet_valid_o  out  1               packet_o and packet_len_o are valid
// - packet_ready_i  in   1               consumer takes the packet
// - len_err_o       out  1               one-cycle pulse: header length invalid
// - packet_cnt_o    out  32              count of packets delivered
//
// BEHAVIOUR
// - Reset (rst_i=1 at a clock edge), which overrides all other inputs:
//   state=IDLE, word_ready_o=1, packet_valid_o=0, len_err_o=0, packet_cnt_o=0,
//   packet_o=0, packet_len_o=0, word index=0.
// - Word transfer: a word is accepted when word_valid_i & word_ready_o.
// - Packet transfer: a packet is delivered when packet_valid_o & packet_ready_i.
// - State IDLE, word_ready_o=1:
//   - On an accepted word, take L = word_i[LEN_W-1:0].
//   - If L==0 or L>MAX_WORDS: word dropped, len_err_o=1 for the next cycle,
//     stay in IDLE.
//   - Else if L==1: store the word as word 0, clear the other words, go to EMIT.
//   - Else: store as word 0, clear the other words, index=1, go to COLLECT.
// - State COLLECT, word_ready_o=1:
//   - Each accepted word is stored at the current index, then index increments.
//   - When index reaches L-1 and that word is accepted, go to EMIT.
// - State EMIT, word_ready_o=0:
//   - packet_valid_o=1; packet_o and packet_len_o=L are held stable until delivered.
//   - On delivery: packet_cnt_o increments, go to IDLE. That same cycle
//     word_ready_o stays 0; IDLE accepts words from the next cycle.
// - Latency:
//   - packet_valid_o rises in the cycle after the last word is accepted.
//   - Peak throughput is L words in L+1 cycles.
// - Unused words (index >= L) in packet_o read as zero.
// - flush_i:
//   - In COLLECT: partial packet discarded, go to IDLE, and any word offered
//     that cycle is not accepted (word_ready_o=0 while flush_i=1).
//   - In IDLE: no effect beyond word_ready_o=0.
//   - In EMIT: no effect; the pending packet is still delivered.
// - packet_cnt_o wraps from 2^32-1 to 0.
// - word_valid_i with word_ready_o=0 (EMIT, or flush): the word is not consumed;
//   the upstream source holds it.
// - Reset during COLLECT or EMIT discards everything without delivery or count.
//
// STRUCTURE
// - trdb_pkg gets:
//   - TRDB_WORD_W=32
//   - the typedef enum logic [1:0] {UNPK_IDLE, UNPK_COLLECT, UNPK_EMIT}
//     unpk_state_e
//   - a function that checks header length validity against MAX_WORDS
// - Single module with no sub-module:
//   - FSM
//   - word index counter
//   - MAX_WORDS x 32 packet register
//   - length register
//   - packet counter
//
// TESTING
// - Reset: hold rst_i for 3 cycles with word_valid_i=1
//   -> word_ready_o=1, packet_valid_o=0, packet_cnt_o=0; no word stored.
// - Single-word packet: header 0xABCD0001
//   -> one cycle later packet_valid_o=1, packet_len_o=1,
//      packet_o[31:0]=0xABCD0001, upper words 0.
//   -> Accept with packet_ready_i=1 -> packet_cnt_o=1.
// - Max-length packet with backpressure: header 0x00000004 then 0x11111111,
//   0x22222222, 0x33333333, with packet_ready_i=0 for 5 cycles
//   -> packet_o holds stable, word_ready_o=0 throughout.
//   -> Release: delivery, IDLE, next header accepted one cycle after.
// - Invalid lengths: headers 0x00000000 and 0x00000005 (MAX_WORDS=4)
//   -> len_err_o pulses once per header, no packet, state stays IDLE.
//   -> Following valid header 0x00000002 + 0xDEADBEEF delivers len 2.
// - Flush: header 0x00000003, one payload word, then flush_i=1 with
//   word_valid_i=1 -> word not accepted, no packet delivered.
//   -> Next header 0x00000001 delivers normally.
// - Counter wrap / reset mid-packet:
//   - Force packet_cnt_o to 0xFFFFFFFF, deliver one packet -> 0.
//   - Assert rst_i in COLLECT -> IDLE, no delivery.

Source files
------------

// File: rtl/trdb_pkg.sv
// Shared types and helpers for the trace debugger packet path.
// Word width, unpacker state encoding and header length checks.
package trdb_pkg;

    localparam int TRDB_WORD_W = 32;

    typedef enum logic [1:0] {
        UNPK_IDLE,
        UNPK_COLLECT,
        UNPK_EMIT
    } unpk_state_e;

    // A header length is usable when it covers at least the header
    // itself and fits in the packet register.
    function automatic logic len_valid(
        input int len,
        input int max_words
    );
        return (len != 0) && (len <= max_words);
    endfunction

endpackage

// File: rtl/trdb_packet_unpacker.sv
// Reassembles variable-length trace packets from the packed word stream.
// Header word carries the packet length in words in its low LEN_W bits.
module trdb_packet_unpacker
    import trdb_pkg::*;
#(
    parameter int MAX_WORDS = 4,
    parameter int LEN_W     = 4
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic [TRDB_WORD_W-1:0]         word_i,
    input  logic                           word_valid_i,
    output logic                           word_ready_o,
    input  logic                           flush_i,
    output logic [MAX_WORDS*TRDB_WORD_W-1:0] packet_o,
    output logic [LEN_W-1:0]               packet_len_o,
    output logic                           packet_valid_o,
    input  logic                           packet_ready_i,
    output logic                           len_err_o,
    output logic [31:0]                    packet_cnt_o
);

    unpk_state_e state_q;
    unpk_state_e state_d;

    logic [MAX_WORDS-1:0][TRDB_WORD_W-1:0] words_q;
    logic [LEN_W-1:0] idx_q;
    logic [LEN_W-1:0] len_q;
    logic             err_q;
    logic [31:0]      cnt_q;

    logic [LEN_W-1:0] hdr_len;
    logic             hdr_ok;
    logic             word_fire;
    logic             pkt_fire;
    logic             last_word;

    assign hdr_len   = word_i[LEN_W-1:0];
    assign hdr_ok    = len_valid(32'(hdr_len), MAX_WORDS);
    assign word_fire = word_valid_i & word_ready_o;
    assign pkt_fire  = packet_valid_o & packet_ready_i;
    assign last_word = (idx_q == len_q - LEN_W'(1));

    // Next state and handshake outputs; EMIT blocks new words.
    always_comb begin
        state_d        = state_q;
        word_ready_o   = 1'b0;
        packet_valid_o = 1'b0;
        unique case (state_q)
            UNPK_IDLE: begin
                word_ready_o = !flush_i;
                if (word_fire && hdr_ok) begin
                    if (hdr_len == LEN_W'(1))
                        state_d = UNPK_EMIT;
                    else
                        state_d = UNPK_COLLECT;
                end
            end
            UNPK_COLLECT: begin
                word_ready_o = !flush_i;
                if (flush_i)
                    state_d = UNPK_IDLE;
                else if (word_fire && last_word)
                    state_d = UNPK_EMIT;
            end
            UNPK_EMIT: begin
                packet_valid_o = 1'b1;
                if (packet_ready_i)
                    state_d = UNPK_IDLE;
            end
            default: state_d = UNPK_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i)
            state_q <= UNPK_IDLE;
        else
            state_q <= state_d;
    end

    // Packet storage, word index, length, error pulse and packet count.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            words_q <= '0;
            idx_q   <= '0;
            len_q   <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            err_q <= (state_q == UNPK_IDLE) && word_fire && !hdr_ok;
            if (state_q == UNPK_IDLE && word_fire && hdr_ok) begin
                words_q    <= '0;
                words_q[0] <= word_i;
                len_q      <= hdr_len;
                idx_q      <= LEN_W'(1);
            end
            if (state_q == UNPK_COLLECT && word_fire) begin
                for (int k = 0; k < MAX_WORDS; k++) begin
                    if (idx_q == LEN_W'(k))
                        words_q[k] <= word_i;
                end
                idx_q <= idx_q + LEN_W'(1);
            end
            if (pkt_fire)
                cnt_q <= cnt_q + 32'd1;
        end
    end

    assign packet_o     = words_q;
    assign packet_len_o = len_q;
    assign len_err_o    = err_q;
    assign packet_cnt_o = cnt_q;

endmodule

// File: tb/tb_trdb_packet_unpacker.sv
// Scoreboard bench for the trace packet unpacker.
// Driver pushes expected packets; a monitor pops them on delivery.
module tb_trdb_packet_unpacker;

    localparam int MW = 4;
    localparam int LW = 4;

    logic           clk = 1'b0;
    logic           rst_i;
    logic [31:0]    word_i;
    logic           word_valid_i;
    logic           word_ready_o;
    logic           flush_i;
    logic [MW*32-1:0] packet_o;
    logic [LW-1:0]  packet_len_o;
    logic           packet_valid_o;
    logic           packet_ready_i;
    logic           len_err_o;
    logic [31:0]    packet_cnt_o;

    trdb_packet_unpacker #(.MAX_WORDS(MW), .LEN_W(LW)) dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .word_i         (word_i),
        .word_valid_i   (word_valid_i),
        .word_ready_o   (word_ready_o),
        .flush_i        (flush_i),
        .packet_o       (packet_o),
        .packet_len_o   (packet_len_o),
        .packet_valid_o (packet_valid_o),
        .packet_ready_i (packet_ready_i),
        .len_err_o      (len_err_o),
        .packet_cnt_o   (packet_cnt_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [MW*32-1:0] data;
        logic [LW-1:0]    len;
    } pkt_t;

    pkt_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   exp_err = 0;
    int   seen_err = 0;
    logic [31:0] exp_cnt = 0;
    int   rdy_mode = 0;

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Offer one word and hold it until accepted (bounded).
    task automatic send_word(input logic [31:0] w, output int waited);
        waited = 0;
        @(negedge clk);
        word_i = w;
        word_valid_i = 1'b1;
        #1;
        while (!word_ready_o && waited < 64) begin
            waited++;
            @(negedge clk);
            #1;
        end
        if (!word_ready_o) chk("word_accept_timeout", 0, 1);
        else @(posedge clk);
        #1 word_valid_i = 1'b0;
    endtask

    // Reference: a header with length L in 1..MW yields a packet of its
    // first L words, zero padded; any other length yields one error.
    task automatic send_packet(input int len_field);
        logic [31:0] w [MW];
        pkt_t p;
        int   waited;
        w[0] = {$urandom_range(0, 32'h0FFF_FFFF), 4'(len_field)};
        for (int k = 1; k < MW; k++) w[k] = $urandom;
        if (len_field == 0 || len_field > MW) begin
            exp_err++;
            send_word(w[0], waited);
        end else begin
            p.data = '0;
            p.len  = LW'(len_field);
            for (int k = 0; k < len_field; k++) p.data[32*k +: 32] = w[k];
            exp_q.push_back(p);
            for (int k = 0; k < len_field; k++) send_word(w[k], waited);
        end
    endtask

    // Consumer ready: random, held low, or held high.
    initial begin
        packet_ready_i = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0: packet_ready_i = ($urandom_range(0, 3) != 0);
                1: packet_ready_i = 1'b0;
                default: packet_ready_i = 1'b1;
            endcase
        end
    end

    // Monitor: delivery check, hold stability, counter and error pulses.
    initial begin
        pkt_t p;
        logic stall = 1'b0;
        logic [MW*32-1:0] hold_d;
        logic [LW-1:0] hold_l;
        forever begin
            @(negedge clk);
            #2;
            if (rst_i) begin
                stall = 1'b0;
            end else begin
                chk("packet_cnt", 128'(packet_cnt_o), 128'(exp_cnt));
                if (len_err_o) seen_err++;
                if (stall) begin
                    chk("hold_valid", 128'(packet_valid_o), 1);
                    chk("hold_data", packet_o, hold_d);
                    chk("hold_len", 128'(packet_len_o), 128'(hold_l));
                end
                stall = packet_valid_o && !packet_ready_i;
                hold_d = packet_o;
                hold_l = packet_len_o;
                if (packet_valid_o && packet_ready_i) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_packet", 128'(packet_len_o), 0);
                    end else begin
                        p = exp_q.pop_front();
                        chk("packet_data", packet_o, p.data);
                        chk("packet_len", 128'(packet_len_o), 128'(p.len));
                    end
                    exp_cnt = exp_cnt + 1;
                end
            end
        end
    end

    initial begin
        int waited;
        int guard;
        rst_i = 1'b1;
        word_i = 32'h1234_0001;
        word_valid_i = 1'b1;
        flush_i = 1'b0;
        exp_cnt = 0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_word_ready", 128'(word_ready_o), 1);
        chk("rst_pkt_valid", 128'(packet_valid_o), 0);
        chk("rst_cnt", 128'(packet_cnt_o), 0);
        chk("rst_data", packet_o, 0);
        word_valid_i = 1'b0;
        rst_i = 1'b0;

        // Single-word packet.
        rdy_mode = 1;
        begin
            pkt_t p;
            p.data = 128'h0;
            p.data[31:0] = 32'hABCD_0001;
            p.len = 4'd1;
            exp_q.push_back(p);
        end
        send_word(32'hABCD_0001, waited);
        @(negedge clk);
        #2;
        chk("single_valid", 128'(packet_valid_o), 1);
        chk("single_len", 128'(packet_len_o), 1);
        chk("single_data", packet_o, 128'hABCD_0001);
        rdy_mode = 2;
        repeat (3) @(negedge clk);
        #2;
        chk("single_cnt", 128'(packet_cnt_o), 1);

        // Max length with backpressure.
        rdy_mode = 1;
        @(posedge clk);
        #1 packet_ready_i = 1'b0;
        begin
            pkt_t p;
            p.data = {32'h3333_3333, 32'h2222_2222,
                      32'h1111_1111, 32'h0000_0004};
            p.len = 4'd4;
            exp_q.push_back(p);
        end
        send_word(32'h0000_0004, waited);
        send_word(32'h1111_1111, waited);
        send_word(32'h2222_2222, waited);
        send_word(32'h3333_3333, waited);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #2;
            chk("bp_word_ready", 128'(word_ready_o), 0);
            chk("bp_valid", 128'(packet_valid_o), 1);
        end
        @(posedge clk);
        #1;
        rdy_mode = 2;
        packet_ready_i = 1'b1;
        begin
            pkt_t p;
            p.data = 128'h0;
            p.data[31:0] = 32'h5555_0001;
            p.len = 4'd1;
            exp_q.push_back(p);
        end
        send_word(32'h5555_0001, waited);
        chk("bp_next_hdr_wait", 128'(waited), 1);
        repeat (3) @(negedge clk);

        // Invalid header lengths.
        rdy_mode = 1;
        @(posedge clk);
        #1 packet_ready_i = 1'b0;
        send_packet(0);
        @(negedge clk);
        #2;
        chk("err0_pulse", 128'(len_err_o), 1);
        chk("err0_no_pkt", 128'(packet_valid_o), 0);
        @(negedge clk);
        #2;
        chk("err0_pulse_end", 128'(len_err_o), 0);
        send_packet(5);
        @(negedge clk);
        #2;
        chk("err5_pulse", 128'(len_err_o), 1);
        chk("err5_idle", 128'(word_ready_o), 1);
        begin
            pkt_t p;
            p.data = {64'h0, 32'hDEAD_BEEF, 32'h0000_0002};
            p.len = 4'd2;
            exp_q.push_back(p);
        end
        rdy_mode = 2;
        send_word(32'h0000_0002, waited);
        send_word(32'hDEAD_BEEF, waited);
        repeat (3) @(negedge clk);

        // Flush mid-packet.
        send_word(32'h0000_0003, waited);
        send_word(32'h7777_7777, waited);
        @(negedge clk);
        word_i = 32'h8888_8888;
        word_valid_i = 1'b1;
        flush_i = 1'b1;
        #1;
        chk("flush_ready", 128'(word_ready_o), 0);
        @(posedge clk);
        #1;
        flush_i = 1'b0;
        word_valid_i = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        chk("flush_no_pkt", 128'(packet_valid_o), 0);
        chk("flush_idle", 128'(word_ready_o), 1);
        send_packet(1);
        repeat (3) @(negedge clk);

        // Counter wrap.
        @(negedge clk);
        #3;
        dut.cnt_q = 32'hFFFF_FFFF;
        exp_cnt = 32'hFFFF_FFFF;
        send_packet(2);
        repeat (3) @(negedge clk);
        #2;
        chk("cnt_wrap", 128'(packet_cnt_o), 0);

        // Reset in COLLECT discards the partial packet.
        send_word(32'h0000_0003, waited);
        send_word(32'h9999_9999, waited);
        @(negedge clk);
        rst_i = 1'b1;
        exp_cnt = 0;
        @(negedge clk);
        rst_i = 1'b0;
        #1;
        chk("rst_mid_ready", 128'(word_ready_o), 1);
        chk("rst_mid_cnt", 128'(packet_cnt_o), 0);
        repeat (4) @(negedge clk);
        #2;
        chk("rst_mid_no_pkt", 128'(packet_valid_o), 0);

        // Random traffic against the reference model.
        rdy_mode = 0;
        for (int i = 0; i < 60; i++) begin
            send_packet($urandom_range(0, 6));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        guard = 0;
        while (exp_q.size() != 0 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        chk("drain", 128'(exp_q.size()), 0);
        repeat (3) @(negedge clk);
        chk("err_count", 128'(seen_err), 128'(exp_err));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
